// File: rtl/clock_period_meter_pkg.sv
// Shared definitions for the clock period meter: FSM encoding and default limits.
// The default timeout is also used by the divider testbench.
package clock_period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_TIMEOUT     = 1000000;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/clock_period_meter_sync_edge_detect.sv
// Brings measclk into the refclk domain and flags its rising edges.
// Edge-to-rise latency is a constant SYNC_STAGES+1 cycles, so measured intervals are exact.
module clock_period_meter_sync_edge_detect
  import clock_period_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic refclk,
  input  logic resetn,
  input  logic measclk,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  always_ff @(posedge refclk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], measclk};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of an asynchronous clock in refclk cycles.
// valid is a one-cycle pulse; period/high_time are stable from that cycle until the next valid.
module clock_period_meter
  import clock_period_meter_pkg::*;
#(
  parameter int unsigned W           = 32,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic         refclk,
  input  logic         resetn,
  input  logic         enable,
  input  logic         measclk,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         valid,
  output logic         timeout,
  output logic         busy,
  output state_t       state
);

  localparam logic [W-1:0] ONE        = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] TIMEOUT_M1 = W'(TIMEOUT - 1);

  logic         s;
  logic         rise;
  state_t       state_n;
  logic [W-1:0] cnt, cnt_n;
  logic [W-1:0] hcnt, hcnt_n;
  logic [W-1:0] period_n, high_n;
  logic         valid_n, timeout_n;

  clock_period_meter_sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .refclk (refclk),
    .resetn (resetn),
    .measclk(measclk),
    .s      (s),
    .rise   (rise)
  );

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v, input logic inc);
    if (inc && (v != '1)) return v + ONE;
    return v;
  endfunction

  always_ff @(posedge refclk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      hcnt      <= hcnt_n;
      period    <= period_n;
      high_time <= high_n;
      valid     <= valid_n;
      timeout   <= timeout_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hcnt_n    = hcnt;
    period_n  = period;
    high_n    = high_time;
    valid_n   = 1'b0;
    timeout_n = timeout;
    // Dropping enable discards any in-flight measurement, even on a rise cycle.
    if (!enable) begin
      state_n   = IDLE;
      cnt_n     = '0;
      hcnt_n    = '0;
      timeout_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_n   = '0;
          hcnt_n  = '0;
          state_n = ARM;
        end
        ARM: begin
          if (rise) begin
            state_n = MEASURE;
            cnt_n   = ONE;
            hcnt_n  = ONE;
          end else if (cnt >= TIMEOUT_M1) begin
            timeout_n = 1'b1;
            cnt_n     = '0;
          end else begin
            cnt_n = sat_inc(cnt, 1'b1);
          end
        end
        MEASURE: begin
          if (rise) begin
            period_n  = cnt;
            high_n    = hcnt;
            valid_n   = 1'b1;
            timeout_n = 1'b0;
            cnt_n     = ONE;
            hcnt_n    = ONE;
          end else if (cnt >= TIMEOUT_M1) begin
            timeout_n = 1'b1;
            cnt_n     = '0;
            hcnt_n    = '0;
            state_n   = ARM;
          end else begin
            cnt_n  = sat_inc(cnt, 1'b1);
            hcnt_n = sat_inc(hcnt, s);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: a table of steady measclk patterns plus
// hand-written sequences for timeout, enable drop, async reset and ratio change.
module tb_clock_period_meter;
  import clock_period_meter_pkg::*;

  localparam int W  = 16;
  localparam int TO = 100;

  logic         refclk  = 1'b0;
  logic         resetn  = 1'b1;
  logic         enable  = 1'b0;
  logic         measclk = 1'b0;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         timeout;
  logic         busy;
  state_t       state;

  int checks   = 0;
  int failures = 0;

  // Each entry is {expected period, expected high_time}.
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_e;

  typedef struct {
    int hi;
    int lo;
    int reps;
    int exp_period;
    int exp_high;
  } vec_t;
  vec_t vecs[6];

  // Clock/reset
  always #5 refclk = ~refclk;

  clock_period_meter #(
    .W          (W),
    .SYNC_STAGES(2),
    .TIMEOUT    (TO)
  ) dut (
    .refclk   (refclk),
    .resetn   (resetn),
    .enable   (enable),
    .measclk  (measclk),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .timeout  (timeout),
    .busy     (busy),
    .state    (state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Scoreboard: every valid must match the oldest outstanding expectation.
  always @(negedge refclk) begin
    if (resetn && valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=period %0d high %0d required=no valid", period, high_time);
      end else begin
        mon_e = exp_q.pop_front();
        check("period", 32'(period), 32'(mon_e[2*W-1:W]));
        check("high_time", 32'(high_time), 32'(mon_e[W-1:0]));
        check("timeout_at_valid", 32'(timeout), 32'd0);
      end
    end
  end

  // Driver tasks
  task automatic drive_period(input int hi, input int lo, input bit push, input int ep, input int eh);
    logic [W-1:0] p;
    logic [W-1:0] h;
    p = ep[W-1:0];
    h = eh[W-1:0];
    if (push) exp_q.push_back({p, h});
    repeat (hi) begin @(negedge refclk); measclk = 1'b1; end
    repeat (lo) begin @(negedge refclk); measclk = 1'b0; end
  endtask

  task automatic start_meas();
    measclk = 1'b0;
    @(negedge refclk);
    enable = 1'b0;
    repeat (5) @(negedge refclk);
    enable = 1'b1;
    repeat (3) @(negedge refclk);
    check("busy_armed", 32'(busy), 32'd1);
  endtask

  task automatic finish_seq(input string name);
    repeat (8) @(negedge refclk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_valid actual=%0d pending required=0", name, exp_q.size());
      exp_q.delete();
    end
    enable = 1'b0;
  endtask

  initial begin
    vecs[0] = '{hi: 2, lo: 2, reps: 4, exp_period: 4,  exp_high: 2};
    vecs[1] = '{hi: 3, lo: 7, reps: 4, exp_period: 10, exp_high: 3};
    vecs[2] = '{hi: 4, lo: 4, reps: 3, exp_period: 8,  exp_high: 4};
    vecs[3] = '{hi: 5, lo: 3, reps: 3, exp_period: 8,  exp_high: 5};
    vecs[4] = '{hi: 2, lo: 3, reps: 4, exp_period: 5,  exp_high: 2};
    vecs[5] = '{hi: 6, lo: 2, reps: 3, exp_period: 8,  exp_high: 6};

    #2 resetn = 1'b0;
    repeat (3) @(negedge refclk);
    check("reset_period", 32'(period), 32'd0);
    check("reset_high_time", 32'(high_time), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_timeout", 32'(timeout), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_state", 32'(state), 32'(IDLE));
    @(negedge refclk);
    resetn = 1'b1;
    @(negedge refclk);

    // Steady patterns: n rises give n-1 valids.
    for (int i = 0; i < 6; i++) begin
      start_meas();
      for (int r = 0; r < vecs[i].reps; r++)
        drive_period(vecs[i].hi, vecs[i].lo, r < vecs[i].reps - 1, vecs[i].exp_period, vecs[i].exp_high);
      finish_seq($sformatf("vec%0d", i));
    end

    // Timeout: sticky flag exactly TO cycles after entering ARM, cleared by the next valid.
    measclk = 1'b0;
    @(negedge refclk);
    enable = 1'b0;
    repeat (5) @(negedge refclk);
    enable = 1'b1;
    @(posedge refclk);
    repeat (TO - 1) @(posedge refclk);
    #1 check("timeout_early", 32'(timeout), 32'd0);
    @(posedge refclk);
    #1 check("timeout_set", 32'(timeout), 32'd1);
    check("timeout_period_held", 32'(period), 32'd8);
    for (int r = 0; r < 3; r++) drive_period(3, 3, r < 2, 6, 3);
    finish_seq("timeout_recover");

    // Enable dropped one cycle before, and in the same cycle as, an expected rise.
    for (int k = 1; k <= 2; k++) begin
      start_meas();
      drive_period(2, 2, 1'b1, 4, 2);
      drive_period(2, 2, 1'b1, 4, 2);
      drive_period(2, 2, 1'b0, 0, 0);
      @(negedge refclk);
      measclk = 1'b1;
      repeat (k) @(negedge refclk);
      enable = 1'b0;
      @(posedge refclk);
      #1 check($sformatf("drop%0d_busy", k), 32'(busy), 32'd0);
      check($sformatf("drop%0d_period_held", k), 32'(period), 32'd4);
      check($sformatf("drop%0d_high_held", k), 32'(high_time), 32'd2);
      @(negedge refclk);
      measclk = 1'b0;
      start_meas();
      for (int r = 0; r < 3; r++) drive_period(3, 3, r < 2, 6, 3);
      finish_seq($sformatf("drop%0d_reenable", k));
    end

    // Async reset in the middle of a measurement.
    start_meas();
    drive_period(2, 2, 1'b1, 4, 2);
    drive_period(2, 2, 1'b1, 4, 2);
    drive_period(2, 2, 1'b0, 0, 0);
    @(posedge refclk);
    #2 resetn = 1'b0;
    #1;
    check("midreset_period", 32'(period), 32'd0);
    check("midreset_high_time", 32'(high_time), 32'd0);
    check("midreset_valid", 32'(valid), 32'd0);
    check("midreset_timeout", 32'(timeout), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    measclk = 1'b0;
    @(negedge refclk);
    resetn = 1'b1;
    repeat (3) @(negedge refclk);
    for (int r = 0; r < 3; r++) drive_period(3, 5, r < 2, 8, 3);
    finish_seq("after_reset");

    // Ratio change N=4 -> N=8 with a stretched low phase in between.
    start_meas();
    for (int r = 0; r < 3; r++) drive_period(2, 2, 1'b1, 4, 2);
    drive_period(2, 5, 1'b1, 7, 2);
    drive_period(4, 4, 1'b1, 8, 4);
    drive_period(4, 4, 1'b1, 8, 4);
    drive_period(4, 4, 1'b0, 0, 0);
    finish_seq("ratio_change");
    repeat (2) @(negedge refclk);
    check("ratio_final_period", 32'(period), 32'd8);
    check("ratio_final_high", 32'(high_time), 32'd4);
    check("idle_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=no completion required=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/clock_period_meter.md
Name: clock_period_meter

Overview:
Measures an asynchronous input clock against refclk. It reports the period and the high time of that clock as counts of refclk cycles. It is the receive-side counterpart of the team's clock divider: feeding it a divider output of ratio N yields period = N. It is used for self-test of generated clocks and for frequency readout on the board display.

Parameters:
W, 32, width of the period and high-time counters and outputs
SYNC_STAGES, 2, synchronizer flop stages on measclk (≥2)
TIMEOUT, 1000000, refclk cycles without a detected rising edge before timeout is flagged; must be < 2^W-1

Ports:
refclk  in  1  reference/system clock; all logic on its rising edge
resetn  in  1  asynchronous, active-low reset
enable  in  1  measurement enable, synchronous to refclk
measclk  in  1  clock under test, asynchronous to refclk
period  out  W  last measured rising-to-rising interval, in refclk cycles
high_time  out  W  last measured high-phase length, in refclk cycles
valid  out  1  one-cycle pulse when period/high_time are updated
timeout  out  1  sticky flag: no rising edge seen within TIMEOUT cycles
busy  out  1  1 whenever state ≠ IDLE

Behaviour:
- Reset (async, resetn=0): synchronizer flops 0; state IDLE; cnt, hcnt, period, high_time 0; valid, timeout, busy 0.
- Front end: measclk passes through SYNC_STAGES flops to give s. A delay register gives s_d. rise = s & ~s_d (one-cycle pulse). Latency from a measclk edge to rise is SYNC_STAGES+1 refclk cycles, constant, so intervals are exact.
- State IDLE: cnt=0. enable=1 → ARM next cycle.
- State ARM: waits for the first rise. cnt increments each cycle. On rise → MEASURE with cnt<=1 and hcnt<=1. If cnt reaches TIMEOUT → timeout<=1, cnt<=0, stay ARM.
- State MEASURE:
  - Cycles without rise: cnt<=cnt+1. hcnt<=hcnt+s.
  - On rise: period<=cnt, high_time<=hcnt, valid<=1 for exactly one cycle, timeout<=0, cnt<=1, hcnt<=1. Stay in MEASURE; back-to-back measurements need no gaps.
  - If cnt reaches TIMEOUT → timeout<=1, go to ARM with cnt<=0. No valid is issued.
- Arithmetic: cnt and hcnt saturate at 2^W-1 and never wrap. Because TIMEOUT < 2^W-1, saturation is only a safety net.
- enable=0 in any state → IDLE next cycle. The in-flight measurement is discarded with no valid. timeout clears. period and high_time hold their last values.
- enable=0 in the same cycle as rise: enable wins; no valid.
- Re-enable always re-arms: the first valid needs two rises after entering ARM.
- Input limits: measclk high and low phases must each be ≥ 2 refclk cycles for exact results. Faster inputs may alias, but the FSM must never lock up.
- Outputs are registered; valid is high for one cycle only.

Decomposition:
- Shared package: state encoding localparams (IDLE, ARM, MEASURE) and the default TIMEOUT constant shared with the divider testbench.
- One sub-module, sync_edge_detect: parameterised SYNC_STAGES synchronizer plus delay register. Outputs level s and pulse rise. Reset is async active-low to 0.

Test Plan:
1. measclk from a clock divider with N=4, enable=1 → first valid after two rises. Then valid every 4 cycles with period=4, high_time=2.
2. measclk with 3 high / 7 low refclk cycles → period=10, high_time=3 on every valid.
3. TIMEOUT=100, measclk held 0, enable=1 → timeout=1 exactly 100 cycles after entering ARM, valid never. measclk then toggles at N=6 → valid with period=6, and timeout cleared in the same cycle.
4. enable dropped 2 cycles before an expected rise → no valid, busy=0 next cycle, period keeps its old value. After re-enable, exactly two rises are needed before the next valid.
5. resetn pulsed low mid-MEASURE, between refclk edges → all outputs 0 immediately. After release, no valid until two rises are seen.
6. Divider switched from N=4 to N=8 between rises → one valid with period equal to the exact rise-to-rise cycle count, then steady period=8, high_time=4.
